// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from an internal bit counter.
// Bytes are presented on a valid/ready pair with sticky error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic             rxd_meta_q, rxd_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             done;

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q & ~err_clr;
        overrun_d   = overrun_q & ~err_clr;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rxd_s_q) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (tick) begin
                    if (!rxd_s_q) begin
                        state_d   = DATA;
                        cnt_d     = CNT_BIT;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rxd_s_q, shift_q[7:1]};
                    cnt_d   = CNT_BIT;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxd_s_q) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completion in the same cycle as an accept replaces the byte.
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != IDLE);

endmodule
